// File: rtl/midilib_onchip_ram_pipelined.sv
// -----------------------------------------------------------------------------
// midilib_onchip_ram_pipelined
//
// Single-port on-chip RAM with an Avalon-MM slave interface. It serves as
// Nios II data and sample memory in the MIDI synthesis system.
//
// Features:
//   - configurable word width and depth
//   - byte-enabled writes with zero wait states
//   - pipelined reads with readdatavalid (latency 1 or 2)
//   - a zeroise engine that walks the whole array writing zeros, either after
//     reset (CLEAR_ON_RESET=1) or when clear_req is pulsed
//
// Ports:
//   clk            sole clock, rising edge
//   reset_n        asynchronous active-low reset
//   address        word address
//   byteenable     per-byte write enable
//   chipselect     slave select
//   read / write   access requests (write wins when both are high)
//   writedata      write data
//   clken          global clock enable; low freezes every register
//   clear_req      single-cycle pulse requesting a runtime zeroise
//   readdata       read data, qualified by readdatavalid
//   readdatavalid  readdata valid this cycle
//   waitrequest    request not accepted this cycle
//   clear_busy     zeroise in progress
//
// Initial contents from INIT_FILE are attached to the array by the vendor
// memory-initialisation flow. They only matter when CLEAR_ON_RESET=0.
// -----------------------------------------------------------------------------
module midilib_onchip_ram_pipelined #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 12,
  parameter int READ_LATENCY   = 1,
  parameter bit CLEAR_ON_RESET = 1'b1,
  parameter     INIT_FILE      = "midilib_onchip_ram.hex"
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [ADDR_WIDTH-1:0]   address,
  input  logic [DATA_WIDTH/8-1:0] byteenable,
  input  logic                    chipselect,
  input  logic                    read,
  input  logic                    write,
  input  logic [DATA_WIDTH-1:0]   writedata,
  input  logic                    clken,
  input  logic                    clear_req,
  output logic [DATA_WIDTH-1:0]   readdata,
  output logic                    readdatavalid,
  output logic                    waitrequest,
  output logic                    clear_busy
);

  localparam int DEPTH     = 1 << ADDR_WIDTH;
  localparam int NUM_BYTES = DATA_WIDTH / 8;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;
  localparam logic [0:0] ST_RESET = CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {ADDR_WIDTH{1'b1}};

  // ---------------------------------------------------------------------------
  // Elaboration-time parameter sanity checks
  // ---------------------------------------------------------------------------
  generate
    if ((DATA_WIDTH <= 0) || ((DATA_WIDTH % 8) != 0)) begin : g_bad_width
      $error("DATA_WIDTH must be a positive multiple of 8");
    end
    if ((READ_LATENCY != 1) && (READ_LATENCY != 2)) begin : g_bad_latency
      $error("READ_LATENCY must be 1 or 2");
    end
    if (!CLEAR_ON_RESET && (INIT_FILE == "")) begin : g_no_init_file
      $warning("CLEAR_ON_RESET=0 without INIT_FILE: RAM contents start undefined");
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Zeroise FSM
  // ---------------------------------------------------------------------------
  logic [0:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] clr_addr_q, clr_addr_d;
  logic                  busy;

  assign busy        = (state_q == ST_CLEAR);
  assign clear_busy  = busy;
  // Depends only on state and clken, never on read/write. This keeps the
  // master free of combinational loops through the request.
  assign waitrequest = busy | ~clken;

  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    // A low clken freezes the FSM. A clear_req pulse during the freeze is
    // therefore ignored, just as it is while a clear is already running.
    if (clken) begin
      if (state_q == ST_IDLE) begin
        if (clear_req) begin
          state_d    = ST_CLEAR;
          clr_addr_d = '0;
        end
      end else begin
        if (clr_addr_q == LAST_ADDR) begin
          state_d = ST_IDLE;
        end else begin
          clr_addr_d = clr_addr_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_RESET;
      clr_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Bus accept decode
  // ---------------------------------------------------------------------------
  logic bus_accept;
  logic wr_accept;
  logic rd_accept;

  // waitrequest already contains ~clken, so an accept implies clken is high.
  assign bus_accept = chipselect & (read | write) & ~waitrequest;
  assign wr_accept  = bus_accept & write;
  // When read and write are both high, only the write takes effect.
  assign rd_accept  = bus_accept & read & ~write;

  // ---------------------------------------------------------------------------
  // Single write port, shared between the bus and the zeroise engine.
  // The two never compete: bus accepts are blocked while the clear runs.
  // ---------------------------------------------------------------------------
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [NUM_BYTES-1:0]  mem_be;

  always_comb begin
    mem_we    = wr_accept;
    mem_addr  = address;
    mem_wdata = writedata;
    mem_be    = byteenable;
    if (busy) begin
      mem_we    = clken;
      mem_addr  = clr_addr_q;
      mem_wdata = '0;
      mem_be    = {NUM_BYTES{1'b1}};
    end
  end

  logic [DATA_WIDTH-1:0] ram_q [DEPTH];

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < NUM_BYTES; b++) begin
        if (mem_be[b]) begin
          ram_q[mem_addr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read stage 1: registered array read.
  // Reads never coincide with a write, because write wins and the clear
  // blocks accepts. There is therefore no read-during-write case to resolve.
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic                  rd_vld_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_data_q <= '0;
      rd_vld_q  <= 1'b0;
    end else if (clken) begin
      rd_vld_q <= rd_accept;
      if (rd_accept) begin
        rd_data_q <= ram_q[address];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output stage.
  // Valid bits hold while clken is low, and the output valid is gated with
  // clken. A result that falls due during a freeze therefore appears exactly
  // once, on the first cycle clken is high again.
  // ---------------------------------------------------------------------------
  generate
    if (READ_LATENCY == 2) begin : g_lat2
      logic [DATA_WIDTH-1:0] out_data_q;
      logic                  out_vld_q;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          out_data_q <= '0;
          out_vld_q  <= 1'b0;
        end else if (clken) begin
          out_vld_q <= rd_vld_q;
          if (rd_vld_q) begin
            out_data_q <= rd_data_q;
          end
        end
      end

      assign readdata      = out_data_q;
      assign readdatavalid = out_vld_q & clken;
    end else begin : g_lat1
      assign readdata      = rd_data_q;
      assign readdatavalid = rd_vld_q & clken;
    end
  endgenerate

endmodule

// File: tb/tb_midilib_onchip_ram_pipelined.sv
// -----------------------------------------------------------------------------
// Testbench for midilib_onchip_ram_pipelined.
//
// Two instances share every input:
//   dut  READ_LATENCY=1
//   dut2 READ_LATENCY=2
//
// Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_midilib_onchip_ram_pipelined;

  localparam int DW = 32;
  localparam int AW = 12;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [AW-1:0] address;
  logic [3:0]    byteenable;
  logic          chipselect;
  logic          read;
  logic          write;
  logic [DW-1:0] writedata;
  logic          clken;
  logic          clear_req;

  logic [DW-1:0] readdata;
  logic          readdatavalid;
  logic          waitrequest;
  logic          clear_busy;

  logic [DW-1:0] readdata2;
  logic          readdatavalid2;
  logic          waitrequest2;
  logic          clear_busy2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  midilib_onchip_ram_pipelined #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(1), .CLEAR_ON_RESET(1'b1)
  ) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .byteenable(byteenable),
    .chipselect(chipselect), .read(read), .write(write), .writedata(writedata),
    .clken(clken), .clear_req(clear_req), .readdata(readdata),
    .readdatavalid(readdatavalid), .waitrequest(waitrequest), .clear_busy(clear_busy)
  );

  midilib_onchip_ram_pipelined #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(2), .CLEAR_ON_RESET(1'b1)
  ) dut2 (
    .clk(clk), .reset_n(reset_n), .address(address), .byteenable(byteenable),
    .chipselect(chipselect), .read(read), .write(write), .writedata(writedata),
    .clken(clken), .clear_req(clear_req), .readdata(readdata2),
    .readdatavalid(readdatavalid2), .waitrequest(waitrequest2), .clear_busy(clear_busy2)
  );

  task automatic bus_idle();
    chipselect = 1'b0;
    read       = 1'b0;
    write      = 1'b0;
    byteenable = 4'b0000;
    writedata  = '0;
    clear_req  = 1'b0;
  endtask

  // Called at a falling edge; returns at the falling edge after the accept.
  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] be);
    chipselect = 1'b1;
    write      = 1'b1;
    address    = a;
    writedata  = d;
    byteenable = be;
    @(negedge clk);
    bus_idle();
    $display("WR addr=%03h data=%08h be=%b", a, d, be);
  endtask

  // Latency-1 read on dut. The single valid cycle is checked inline.
  task automatic rd1(input logic [AW-1:0] a, input logic [DW-1:0] exp, input string name);
    chipselect = 1'b1;
    read       = 1'b1;
    address    = a;
    @(negedge clk);
    bus_idle();
    checks++;
    if (readdatavalid !== 1'b1) begin
      errors++;
      $display("FAIL %s valid: got %b expected 1", name, readdatavalid);
    end
    checks++;
    if (readdata !== exp) begin
      errors++;
      $display("FAIL %s data: got %08h expected %08h", name, readdata, exp);
    end
    $display("RD addr=%03h data=%08h (%s)", a, readdata, name);
    @(negedge clk);
    checks++;
    if (readdatavalid !== 1'b0) begin
      errors++;
      $display("FAIL %s single valid: got %b expected 0", name, readdatavalid);
    end
  endtask

  task automatic test_reset();
    int n;
    reset_n = 1'b0;
    clken   = 1'b1;
    address = '0;
    bus_idle();
    repeat (3) @(negedge clk);
    checks++;
    if (readdata !== 32'h0) begin
      errors++;
      $display("FAIL reset readdata: got %08h expected 00000000", readdata);
    end
    checks++;
    if (readdatavalid !== 1'b0) begin
      errors++;
      $display("FAIL reset readdatavalid: got %b expected 0", readdatavalid);
    end
    checks++;
    if (clear_busy !== 1'b1) begin
      errors++;
      $display("FAIL reset clear_busy: got %b expected 1", clear_busy);
    end
    checks++;
    if (waitrequest !== 1'b1) begin
      errors++;
      $display("FAIL reset waitrequest: got %b expected 1", waitrequest);
    end
    reset_n = 1'b1;
    n = 0;
    while ((waitrequest === 1'b1) && (n < 10000)) begin
      n++;
      @(negedge clk);
    end
    checks++;
    if (n != 4096) begin
      errors++;
      $display("FAIL reset clear length: got %0d cycles expected 4096", n);
    end
    $display("RESET clear done after %0d cycles", n);
    rd1(12'h000, 32'h0, "reset_rd0");
    rd1(12'h001, 32'h0, "reset_rd1");
    rd1(12'hFFF, 32'h0, "reset_rd4095");
  endtask

  task automatic test_byteenable();
    wr(12'h010, 32'hDEADBEEF, 4'b1111);
    wr(12'h010, 32'h00AA0000, 4'b0100);
    rd1(12'h010, 32'hDEAABEEF, "be_merge");
    wr(12'h010, 32'hFFFFFFFF, 4'b0000);
    rd1(12'h010, 32'hDEAABEEF, "be_zero_noop");
    // Not selected: must not produce a read.
    chipselect = 1'b0;
    read       = 1'b1;
    address    = 12'h010;
    @(negedge clk);
    bus_idle();
    checks++;
    if (readdatavalid !== 1'b0) begin
      errors++;
      $display("FAIL nocs valid: got %b expected 0", readdatavalid);
    end
    $display("RD addr=010 chipselect=0 (ignored)");
    // Read and write together: the write lands, the read produces no valid.
    chipselect = 1'b1;
    read       = 1'b1;
    write      = 1'b1;
    address    = 12'h011;
    writedata  = 32'h00000055;
    byteenable = 4'b1111;
    @(negedge clk);
    bus_idle();
    checks++;
    if (readdatavalid !== 1'b0) begin
      errors++;
      $display("FAIL rdwr valid: got %b expected 0", readdatavalid);
    end
    $display("RDWR addr=011 data=00000055");
    // Write immediately followed by a read of the same word.
    wr(12'h011, 32'hA5A55A5A, 4'b1111);
    rd1(12'h011, 32'hA5A55A5A, "wr_then_rd");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) wr(AW'(i), DW'(i), 4'b1111);
    for (int j = 0; j < 12; j++) begin
      if (j < 8) begin
        chipselect = 1'b1;
        read       = 1'b1;
        address    = AW'(j);
      end else begin
        bus_idle();
      end
      @(negedge clk);
      // j+1 falling edges after the first read was driven.
      checks++;
      if (readdatavalid !== ((j + 1 >= 1) && (j + 1 <= 8))) begin
        errors++;
        $display("FAIL b2b lat1 valid k=%0d: got %b", j + 1, readdatavalid);
      end
      if ((j + 1 >= 1) && (j + 1 <= 8)) begin
        checks++;
        if (readdata !== DW'(j)) begin
          errors++;
          $display("FAIL b2b lat1 data k=%0d: got %08h expected %08h", j + 1, readdata, DW'(j));
        end
      end
      checks++;
      if (readdatavalid2 !== ((j + 1 >= 2) && (j + 1 <= 9))) begin
        errors++;
        $display("FAIL b2b lat2 valid k=%0d: got %b", j + 1, readdatavalid2);
      end
      if ((j + 1 >= 2) && (j + 1 <= 9)) begin
        checks++;
        if (readdata2 !== DW'(j - 1)) begin
          errors++;
          $display("FAIL b2b lat2 data k=%0d: got %08h expected %08h", j + 1, readdata2, DW'(j - 1));
        end
      end
      $display("B2B k=%0d v1=%b d1=%08h v2=%b d2=%08h", j + 1, readdatavalid, readdata,
               readdatavalid2, readdata2);
    end
    bus_idle();
  endtask

  task automatic test_freeze();
    chipselect = 1'b1;
    read       = 1'b1;
    address    = 12'h003;
    @(negedge clk);
    // The lat-1 result is due now. Freeze, and keep a read (addr 5) pending
    // that must not be accepted.
    clken   = 1'b0;
    address = 12'h005;
    for (int c = 0; c < 3; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      checks++;
      if (readdatavalid !== 1'b0) begin
        errors++;
        $display("FAIL freeze valid c=%0d: got %b expected 0", c, readdatavalid);
      end
      checks++;
      if (waitrequest !== 1'b1) begin
        errors++;
        $display("FAIL freeze waitrequest c=%0d: got %b expected 1", c, waitrequest);
      end
      checks++;
      if (readdatavalid2 !== 1'b0) begin
        errors++;
        $display("FAIL freeze lat2 valid c=%0d: got %b expected 0", c, readdatavalid2);
      end
    end
    @(negedge clk);
    clken = 1'b1;
    bus_idle();
    #1;
    checks++;
    if ((readdatavalid !== 1'b1) || (readdata !== 32'h3)) begin
      errors++;
      $display("FAIL thaw lat1: got v=%b d=%08h expected v=1 d=00000003", readdatavalid, readdata);
    end
    checks++;
    if (readdatavalid2 !== 1'b0) begin
      errors++;
      $display("FAIL thaw lat2 early: got %b expected 0", readdatavalid2);
    end
    $display("FREEZE released, lat1 data=%08h", readdata);
    @(negedge clk);
    checks++;
    if (readdatavalid !== 1'b0) begin
      errors++;
      $display("FAIL thaw lat1 dup: got %b expected 0", readdatavalid);
    end
    checks++;
    if ((readdatavalid2 !== 1'b1) || (readdata2 !== 32'h3)) begin
      errors++;
      $display("FAIL thaw lat2: got v=%b d=%08h expected v=1 d=00000003", readdatavalid2, readdata2);
    end
    @(negedge clk);
    checks++;
    if ((readdatavalid !== 1'b0) || (readdatavalid2 !== 1'b0)) begin
      errors++;
      $display("FAIL thaw extra valid: got %b/%b expected 0/0", readdatavalid, readdatavalid2);
    end
  endtask

  task automatic test_clear();
    int n;
    wr(12'h020, 32'h12345678, 4'b1111);
    // Read accepted on the same cycle as clear_req returns pre-clear data.
    chipselect = 1'b1;
    read       = 1'b1;
    address    = 12'h020;
    clear_req  = 1'b1;
    @(negedge clk);
    bus_idle();
    checks++;
    if ((readdatavalid !== 1'b1) || (readdata !== 32'h12345678)) begin
      errors++;
      $display("FAIL clear pre-read: got v=%b d=%08h expected v=1 d=12345678", readdatavalid, readdata);
    end
    checks++;
    if (clear_busy !== 1'b1) begin
      errors++;
      $display("FAIL clear start busy: got %b expected 1", clear_busy);
    end
    n = 1;
    while (n < 10000) begin
      // A second request mid-clear, and a write that must stay stalled.
      clear_req  = (n == 100);
      chipselect = (n == 50);
      write      = (n == 50);
      address    = 12'h021;
      writedata  = 32'hFFFFFFFF;
      byteenable = 4'b1111;
      @(negedge clk);
      if (clear_busy !== 1'b1) break;
      n++;
    end
    bus_idle();
    checks++;
    if (n != 4096) begin
      errors++;
      $display("FAIL clear length: got %0d cycles expected 4096", n);
    end
    $display("CLEAR done after %0d cycles", n);
    rd1(12'h020, 32'h0, "clear_rd020");
    rd1(12'h021, 32'h0, "clear_rd021");
    rd1(12'h010, 32'h0, "clear_rd010");
  endtask

  task automatic test_reset_mid_clear();
    int n;
    wr(12'h040, 32'hCAFEF00D, 4'b1111);
    rd1(12'h040, 32'hCAFEF00D, "pre_reset_rd");
    @(negedge clk);
    checks++;
    if (readdata2 !== 32'hCAFEF00D) begin
      errors++;
      $display("FAIL pre_reset lat2 data: got %08h expected cafef00d", readdata2);
    end
    clear_req = 1'b1;
    @(negedge clk);
    clear_req = 1'b0;
    repeat (2047) @(negedge clk);
    reset_n = 1'b0;
    for (int c = 0; c < 3; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      checks++;
      if ((readdata !== 32'h0) || (readdata2 !== 32'h0)) begin
        errors++;
        $display("FAIL midreset readdata c=%0d: got %08h/%08h expected 0", c, readdata, readdata2);
      end
      checks++;
      if ((readdatavalid !== 1'b0) || (clear_busy !== 1'b1)) begin
        errors++;
        $display("FAIL midreset v/busy c=%0d: got %b/%b expected 0/1", c, readdatavalid, clear_busy);
      end
    end
    @(negedge clk);
    reset_n = 1'b1;
    n = 0;
    while ((clear_busy === 1'b1) && (n < 10000)) begin
      n++;
      @(negedge clk);
    end
    checks++;
    if (n != 4096) begin
      errors++;
      $display("FAIL midreset clear length: got %0d cycles expected 4096", n);
    end
    $display("MIDRESET clear done after %0d cycles", n);
    rd1(12'h040, 32'h0, "post_reset_rd040");
  endtask

  initial begin
    test_reset();
    test_byteenable();
    test_back_to_back();
    test_freeze();
    test_clear();
    test_reset_mid_clear();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
